// File: rtl/dilithium_pkg.sv
// -----------------------------------------------------------------------------
// dilithium_pkg
// Shared constants and types for the Dilithium matrix-expansion datapath.
//   Q                  : modulus; sampled coefficients lie in [0, Q)
//   N                  : coefficients per polynomial
//   COEF_W             : coefficient width in bits
//   IDX_W              : coefficient index width in bits
//   BLK_BYTES_SHAKE128 : squeeze rate of SHAKE128 in bytes
//   BLK_BYTES_SHAKE256 : squeeze rate of SHAKE256 in bytes
//   rej_state_t        : state encoding of the rejection sampler FSM
// -----------------------------------------------------------------------------
package dilithium_pkg;

    localparam int Q                  = 8380417;
    localparam int N                  = 256;
    localparam int COEF_W             = 23;
    localparam int IDX_W              = 8;
    localparam int BLK_BYTES_SHAKE128 = 168;
    localparam int BLK_BYTES_SHAKE256 = 136;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SAMPLE,
        ST_WAIT_REL,
        ST_DRAIN,
        ST_DONE
    } rej_state_t;

endpackage

// File: rtl/rej_uniform_sampler_if.sv
// -----------------------------------------------------------------------------
// rej_uniform_sampler_if
// Bundles the three handshakes around the rejection sampler.
//   rtr / rts               : start request from, and completion to, the
//                             matrix-expansion controller
//   blk_req / blk_rts       : block request to, and block ready from, SHAKE
//   blk_data                : one squeezed block; stream byte i sits at
//                             blk_data[8*BLK_BYTES-1-8i -: 8]
//   coef_valid / coef_ready : coefficient stream handshake
//   coef_data / coef_idx    : sampled coefficient and its index
// Modport slave is the sampler's view, master is the surrounding system's.
// -----------------------------------------------------------------------------
interface rej_uniform_sampler_if #(
    parameter int BLK_BYTES = dilithium_pkg::BLK_BYTES_SHAKE128
);
    import dilithium_pkg::*;

    logic                   rtr;
    logic                   rts;
    logic                   blk_req;
    logic                   blk_rts;
    logic [8*BLK_BYTES-1:0] blk_data;
    logic                   coef_valid;
    logic                   coef_ready;
    logic [COEF_W-1:0]      coef_data;
    logic [IDX_W-1:0]       coef_idx;

    modport slave (
        input  rtr, blk_rts, blk_data, coef_ready,
        output rts, blk_req, coef_valid, coef_data, coef_idx
    );

    modport master (
        output rtr, blk_rts, blk_data, coef_ready,
        input  rts, blk_req, coef_valid, coef_data, coef_idx
    );

endinterface

// File: rtl/rej_cand_extract.sv
// -----------------------------------------------------------------------------
// rej_cand_extract
// Combinational candidate extraction for RejUniform.
//   blk_buf : buffered squeezed block (stream byte 0 in the top byte)
//   k       : candidate number within the block, 0..BLK_BYTES/3-1
//   t       : b[3k] | b[3k+1]<<8 | (b[3k+2] & 0x7F)<<16
//   accept  : t < Q
// -----------------------------------------------------------------------------
module rej_cand_extract
    import dilithium_pkg::*;
#(
    parameter  int BLK_BYTES = BLK_BYTES_SHAKE128,
    localparam int K         = BLK_BYTES / 3,
    localparam int KW        = $clog2(K)
) (
    input  logic [8*BLK_BYTES-1:0] blk_buf,
    input  logic [KW-1:0]          k,
    output logic [COEF_W-1:0]      t,
    output logic                   accept
);

    logic [COEF_W-1:0] cand [K];
    // The top bit of every third byte is masked away by the algorithm.
    logic [K-1:0]      unused_msbs;

    // Stream bytes are stored big-end first, so candidate g starts at the
    // top of the buffer and walks downward 24 bits at a time; the first byte
    // of each triple is the least significant one.
    for (genvar g = 0; g < K; g++) begin : g_cand
        localparam int HI = 8*BLK_BYTES - 1 - 24*g;
        assign cand[g]        = {blk_buf[HI-17 -: 7], blk_buf[HI-8 -: 8], blk_buf[HI -: 8]};
        assign unused_msbs[g] = blk_buf[HI-16];
    end

    // Select the current candidate.
    always_comb begin
        t = '0;
        for (int i = 0; i < K; i++) begin
            if (k == KW'(i)) begin
                t = cand[i];
            end
        end
    end

    assign accept = (t < COEF_W'(Q));

endmodule

// File: rtl/rej_uniform_sampler.sv
// -----------------------------------------------------------------------------
// rej_uniform_sampler
// Dilithium RejUniform sampler for one ExpandA polynomial. Pulls squeezed
// SHAKE128 blocks, tests one 3-byte candidate per cycle and emits exactly N
// accepted coefficients in index order.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : rej_uniform_sampler_if.slave (controller rtr/rts, SHAKE
//           blk_req/blk_rts/blk_data, coefficient valid/ready stream)
// -----------------------------------------------------------------------------
module rej_uniform_sampler
    import dilithium_pkg::*;
#(
    parameter int BLK_BYTES = BLK_BYTES_SHAKE128
) (
    input logic                  clk,
    input logic                  reset,
    rej_uniform_sampler_if.slave bus
);

    localparam int K  = BLK_BYTES / 3;
    localparam int KW = $clog2(K);
    localparam int CW = $clog2(N + 1);

    rej_state_t             state;
    rej_state_t             state_next;
    logic [8*BLK_BYTES-1:0] blk_buf;
    logic [KW-1:0]          k;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_inc;
    logic                   coef_valid;
    logic [COEF_W-1:0]      coef_data;
    logic [IDX_W-1:0]       coef_idx;

    logic [COEF_W-1:0]      cand_t;
    logic                   cand_accept;
    logic                   out_free;
    logic                   do_latch;
    logic                   do_load;
    logic                   k_adv;

    rej_cand_extract #(
        .BLK_BYTES (BLK_BYTES)
    ) u_extract (
        .blk_buf (blk_buf),
        .k       (k),
        .t       (cand_t),
        .accept  (cand_accept)
    );

    assign cnt_inc  = cnt + CW'(1);
    assign out_free = !coef_valid || bus.coef_ready;

    // Next-state and per-cycle control. A candidate is only consumed when it
    // is rejected or when the output register can take it; otherwise k holds.
    // REQ is entered only with blk_rts low so a stale ready from the previous
    // block is never mistaken for a fresh one.
    always_comb begin
        state_next = state;
        do_latch   = 1'b0;
        do_load    = 1'b0;
        k_adv      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.rtr && !bus.blk_rts) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.blk_rts) begin
                    do_latch   = 1'b1;
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (!(cand_accept && !out_free)) begin
                    do_load = cand_accept;
                    if (cand_accept && (cnt_inc == CW'(N))) begin
                        state_next = ST_DRAIN;
                    end else if (k == KW'(K - 1)) begin
                        state_next = ST_WAIT_REL;
                    end else begin
                        k_adv = 1'b1;
                    end
                end
            end
            ST_WAIT_REL: begin
                if (!bus.blk_rts) begin
                    state_next = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (!coef_valid) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.rtr) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Candidate pointer, coefficient counter and output register. The counter
    // is cleared while idle so each polynomial restarts its indices at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k          <= '0;
            cnt        <= '0;
            coef_valid <= 1'b0;
            coef_data  <= '0;
            coef_idx   <= '0;
        end else begin
            if (do_latch) begin
                k <= '0;
            end else if (k_adv) begin
                k <= k + KW'(1);
            end

            if (state == ST_IDLE) begin
                cnt <= '0;
            end else if (do_load) begin
                cnt <= cnt_inc;
            end

            if (do_load) begin
                coef_valid <= 1'b1;
                coef_data  <= cand_t;
                coef_idx   <= cnt[IDX_W-1:0];
            end else if (coef_valid && bus.coef_ready) begin
                coef_valid <= 1'b0;
            end
        end
    end

    // Block buffer; only captured on the REQ cycle that sees blk_rts, so later
    // changes on blk_data are invisible. Contents after reset do not matter.
    always_ff @(posedge clk) begin
        if (do_latch) begin
            blk_buf <= bus.blk_data;
        end
    end

    assign bus.blk_req    = (state == ST_REQ);
    assign bus.rts        = (state == ST_DONE);
    assign bus.coef_valid = coef_valid;
    assign bus.coef_data  = coef_data;
    assign bus.coef_idx   = coef_idx;

endmodule

// File: tb/tb_rej_uniform_sampler.sv
// -----------------------------------------------------------------------------
// tb_rej_uniform_sampler
// Self-checking bench for rej_uniform_sampler: a SHAKE block source that
// pushes the expected coefficients of every served block into a scoreboard,
// a consumer that pops and compares on each accepted coefficient, and a
// linear directed sequence driving the controller side. The candidate
// extractor is also exercised on its own.
// -----------------------------------------------------------------------------
module tb_rej_uniform_sampler;
    import dilithium_pkg::*;

    localparam int BB = BLK_BYTES_SHAKE128;
    localparam int K  = BB / 3;

    typedef struct packed {
        logic [COEF_W-1:0] data;
        logic [IDX_W-1:0]  idx;
    } coef_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    initial forever #5 clk = ~clk;

    rej_uniform_sampler_if #(.BLK_BYTES(BB)) bus();

    rej_uniform_sampler #(.BLK_BYTES(BB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [8*BB-1:0]   ux_buf;
    logic [5:0]        ux_k;
    logic [COEF_W-1:0] ux_t;
    logic              ux_acc;

    rej_cand_extract #(.BLK_BYTES(BB)) ux (
        .blk_buf (ux_buf),
        .k       (ux_k),
        .t       (ux_t),
        .accept  (ux_acc)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    coef_t sb_q[$];
    int    blk_mode;
    int    bp_mode;
    int    rts_hold;
    bit    scramble;
    int    pushed;
    int    blk_served;
    int    recv;
    int    first_blk_count;
    logic [COEF_W-1:0] first_data [2];
    logic [IDX_W-1:0]  first_idx;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Builds the next block for the current mode, presents it to the sampler
    // and queues every coefficient it should yield (up to N per polynomial).
    task automatic apply_stimulus();
        logic [7:0]        b [BB];
        logic [8*BB-1:0]   v;
        logic [COEF_W-1:0] t;
        for (int i = 0; i < BB; i++) begin
            case (blk_mode)
                2:       b[i] = (blk_served < 3) ? 8'hFF : 8'h00;
                3:       b[i] = 8'($urandom_range(0, 255));
                default: b[i] = 8'h00;
            endcase
        end
        if (blk_mode == 1 && blk_served == 0) begin
            b[0] = 8'h00; b[1]  = 8'hE0; b[2]  = 8'h7F;
            b[3] = 8'h01; b[4]  = 8'hE0; b[5]  = 8'h7F;
            b[6] = 8'hFF; b[7]  = 8'hFF; b[8]  = 8'hFF;
            b[9] = 8'h01; b[10] = 8'h00; b[11] = 8'h80;
        end
        for (int i = 0; i < BB; i++) begin
            v[8*BB-1-8*i -: 8] = b[i];
        end
        for (int c = 0; c < K; c++) begin
            t = {b[3*c+2][6:0], b[3*c+1], b[3*c]};
            if (int'(t) < Q && pushed < N) begin
                sb_q.push_back({t, 8'(pushed)});
                pushed++;
            end
        end
        blk_served++;
        bus.blk_data = v;
        bus.blk_rts  = 1'b1;
    endtask

    // SHAKE model: answers blk_req after two cycles, keeps rts up until the
    // request drops plus rts_hold cycles, optionally trashing blk_data once
    // the block has been latched.
    initial begin : shake_model
        int st;
        int cnt;
        st           = 0;
        cnt          = 0;
        bus.blk_rts  = 1'b0;
        bus.blk_data = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                st          = 0;
                bus.blk_rts = 1'b0;
            end else begin
                case (st)
                    0: if (bus.blk_req === 1'b1) begin cnt = 1; st = 1; end
                    1: begin
                        if (cnt == 0) begin
                            apply_stimulus();
                            st = 2;
                        end else begin
                            cnt--;
                        end
                    end
                    2: begin
                        if (bus.blk_req === 1'b0) begin
                            if (scramble) begin
                                for (int w = 0; w < BB / 4; w++) begin
                                    bus.blk_data[32*w +: 32] = $urandom;
                                end
                            end
                            cnt = rts_hold;
                            st  = 3;
                        end
                    end
                    default: begin
                        check_output("req_while_rts", bus.blk_req, 0);
                        if (cnt == 0) begin
                            bus.blk_rts = 1'b0;
                            st          = 0;
                        end else begin
                            cnt--;
                        end
                    end
                endcase
            end
        end
    end

    // Consumer: picks coef_ready for the coming edge, then scores any
    // transfer that edge will perform and checks that a stalled coefficient
    // is still presented unchanged one cycle later.
    initial begin : consumer
        bit    stall_prev;
        coef_t held;
        coef_t exp_c;
        stall_prev     = 0;
        held           = '0;
        bus.coef_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    check_output("stall_valid", bus.coef_valid, 1);
                    check_output("stall_data", bus.coef_data, held.data);
                    check_output("stall_idx", bus.coef_idx, held.idx);
                end
                stall_prev     = 0;
                bus.coef_ready = (bp_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
                if (bus.coef_valid === 1'b1) begin
                    if (bus.coef_ready) begin
                        check_output("sb_nonempty", sb_q.size() != 0, 1);
                        if (sb_q.size() != 0) begin
                            exp_c = sb_q.pop_front();
                            check_output("coef_data", bus.coef_data, exp_c.data);
                            check_output("coef_idx", bus.coef_idx, exp_c.idx);
                        end
                        if (recv < 2) first_data[recv] = bus.coef_data;
                        if (recv == 0) begin
                            first_blk_count = blk_served;
                            first_idx       = bus.coef_idx;
                        end
                        recv++;
                    end else begin
                        stall_prev = 1;
                        held       = {bus.coef_data, bus.coef_idx};
                    end
                end
            end
        end
    end

    task automatic run_poly(input int mode, input int bp, input int hold, input bit scr,
                            input bit early_drop, input int exp_blocks);
        bit done;
        blk_mode   = mode;
        bp_mode    = bp;
        rts_hold   = hold;
        scramble   = scr;
        pushed     = 0;
        blk_served = 0;
        recv       = 0;
        sb_q.delete();
        @(negedge clk);
        bus.rtr = 1'b1;
        done    = 0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk);
            if (early_drop && recv > 0) bus.rtr = 1'b0;
            if (bus.rts === 1'b1) done = 1;
        end
        check_output("rts_done", done, 1);
        check_output("coef_total", recv, N);
        check_output("sb_drained", sb_q.size(), 0);
        if (exp_blocks > 0) check_output("blk_count", blk_served, exp_blocks);
        bus.rtr = 1'b0;
        @(negedge clk);
        check_output("rts_release", bus.rts, 0);
    endtask

    initial begin
        bit reached;
        bus.rtr  = 1'b0;
        blk_mode = 0;
        bp_mode  = 0;
        rts_hold = 0;
        scramble = 0;
        ux_buf   = '0;
        ux_k     = '0;
        reset    = 1'b0;
        #1;
        check_output("rst_rts", bus.rts, 0);
        check_output("rst_blk_req", bus.blk_req, 0);
        check_output("rst_valid", bus.coef_valid, 0);
        check_output("rst_data", bus.coef_data, 0);
        check_output("rst_idx", bus.coef_idx, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Candidate extractor on its own: boundary triples and the last slot.
        ux_buf[8*BB-1 -: 96] = 96'h00E07F_01E07F_FFFFFF_010080;
        ux_buf[23:0]         = 24'h123456;
        ux_k = 6'd0;  #1; check_output("ux_t0", ux_t, 23'd8380416); check_output("ux_a0", ux_acc, 1);
        ux_k = 6'd1;  #1; check_output("ux_t1", ux_t, 23'h7FE001);  check_output("ux_a1", ux_acc, 0);
        ux_k = 6'd2;  #1; check_output("ux_t2", ux_t, 23'h7FFFFF);  check_output("ux_a2", ux_acc, 0);
        ux_k = 6'd3;  #1; check_output("ux_t3", ux_t, 23'd1);       check_output("ux_a3", ux_acc, 1);
        ux_k = 6'd55; #1; check_output("ux_t55", ux_t, 23'h563412); check_output("ux_a55", ux_acc, 1);

        $display("[TB] all-zero blocks");
        run_poly(0, 0, 0, 0, 0, 5);

        $display("[TB] boundary block");
        run_poly(1, 0, 0, 0, 0, 5);
        check_output("bnd_coef0", first_data[0], 23'd8380416);
        check_output("bnd_coef1", first_data[1], 23'd1);

        $display("[TB] three rejected blocks");
        run_poly(2, 0, 0, 0, 0, 8);
        check_output("ff_blocks_before_coef0", first_blk_count, 4);

        $display("[TB] backpressure with early rtr drop");
        run_poly(0, 1, 0, 0, 1, 5);

        $display("[TB] held blk_rts and scrambled data after latch");
        run_poly(3, 0, 10, 1, 0, 0);

        $display("[TB] reset mid-polynomial");
        blk_mode   = 0;
        bp_mode    = 0;
        rts_hold   = 0;
        scramble   = 0;
        pushed     = 0;
        blk_served = 0;
        recv       = 0;
        sb_q.delete();
        bus.rtr = 1'b1;
        reached = 0;
        for (int c = 0; c < 5000 && !reached; c++) begin
            @(negedge clk);
            if (recv >= 100) reached = 1;
        end
        check_output("reach_cnt100", reached, 1);
        #2 reset = 1'b0;
        #1;
        check_output("mid_rst_rts", bus.rts, 0);
        check_output("mid_rst_blk_req", bus.blk_req, 0);
        check_output("mid_rst_valid", bus.coef_valid, 0);
        check_output("mid_rst_data", bus.coef_data, 0);
        check_output("mid_rst_idx", bus.coef_idx, 0);
        bus.rtr = 1'b0;
        repeat (2) @(negedge clk);
        sb_q.delete();
        #2 reset = 1'b1;
        run_poly(0, 0, 0, 0, 0, 5);
        check_output("restart_idx", first_idx, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rej_uniform_sampler.md
Name: rej_uniform_sampler

Overview:
- Consumes squeezed SHAKE128 output blocks and performs Dilithium RejUniform rejection sampling for one ExpandA polynomial.
- Emits exactly N coefficients in [0, Q).
- Sits directly downstream of the SHAKE core: drives that core's rtr and reads its rts and SHAKEout.
- Is itself started and released by the matrix-expansion controller through the same rtr/rts handshake.

Parameters:
- BLK_BYTES, 168, bytes per squeezed block (SHAKE128 rate); must be a multiple of 3.
- Q, 8380417, modulus; candidates >= Q are rejected.
- N, 256, coefficients per polynomial.
- COEF_W, 23, coefficient width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- rtr  in  1  controller request; level-held until rts seen, then dropped.
- rts  out  1  polynomial complete; held until rtr drops.
- blk_req  out  1  to SHAKE rtr; requests one block.
- blk_rts  in  1  from SHAKE rts; blk_data valid while high.
- blk_data  in  8*BLK_BYTES  SHAKE output; stream byte i = blk_data[8*BLK_BYTES-1-8i -: 8].
- coef_valid  out  1  coef_data/coef_idx valid.
- coef_ready  in  1  consumer accepts when valid && ready.
- coef_data  out  COEF_W  sampled coefficient.
- coef_idx  out  8  index 0..N-1 of coef_data.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; counters cleared; block buffer contents don't-care. Reset mid-operation abandons the polynomial. Upstream SHAKE must be reset alongside.
- Candidate k of the buffered block:
  - t = b[3k] | b[3k+1]<<8 | (b[3k+2] & 0x7F)<<16.
  - Accept iff t < Q.
  - K = BLK_BYTES/3 candidates per block (56 at default).
- IDLE: rts=0; rtr=1 -> REQ next cycle.
- REQ:
  - blk_req=1; entered only when blk_rts=0.
  - On blk_rts=1: latch blk_data into the internal buffer, k<=0; blk_req=0 from the next cycle; go to SAMPLE.
- SAMPLE: one candidate per cycle.
  - Output register is free when coef_valid=0, or when coef_valid && coef_ready in the same cycle.
  - Rejected candidate: k++, no output change.
  - Accepted candidate with output register free: load coef_data=t and coef_idx=cnt, coef_valid<=1, cnt++, k++.
  - Accepted candidate with output register not free: stall; k holds.
  - Processed candidate with k==K-1 and cnt<N (after increment): go to WAIT_REL, then REQ once blk_rts=0.
  - cnt reaches N: go to DRAIN; remaining candidates are discarded.
- WAIT_REL: wait for blk_rts=0 (completes the SHAKE 4-phase release). Pending coef_valid may still drain here.
- DRAIN: wait for the last coefficient to be accepted (coef_valid=0) -> DONE.
- DONE: rts=1; rtr=0 -> IDLE with rts=0 the next cycle.
- rtr deasserting before DONE is ignored; the polynomial always completes.
- Latency:
  - 1 cycle from candidate evaluation to coef_valid.
  - Zero-backpressure throughput: 1 candidate per cycle plus block-fetch overhead.
- Coefficient output:
  - Order strictly increasing, 0..N-1.
  - coef_data and coef_idx stable while coef_valid && !coef_ready.
- blk_data is sampled only in the REQ cycle where blk_rts=1; its later changes have no effect.

Decomposition:
- Shared package dilithium_pkg: Q, N, COEF_W, BLK_BYTES_SHAKE128=168, BLK_BYTES_SHAKE256=136, and the FSM state encoding for IDLE/REQ/SAMPLE/WAIT_REL/DRAIN/DONE.
- Sub-module rej_cand_extract:
  - Combinational.
  - Inputs: block buffer and k.
  - Outputs: t and accept.
  - Isolates the byte-order-reversed indexing and the <Q compare so both can be unit-tested directly.

Test Plan:
- All-zero blocks, coef_ready=1:
  - 256 coefficients of value 0, idx 0..255.
  - Exactly 5 blk_req pulses, since ceil(256/56)=5.
  - rts=1 after the last coefficient; rtr=0 -> rts=0 the next cycle.
- Boundary compare, block starting with bytes 00 E0 7F, 01 E0 7F, FF FF FF, 01 00 80, rest zero:
  - Coefficient 0 = 8380416 (accepted).
  - 0x7FE001 = Q and 0x7FFFFF are rejected.
  - Coefficient 1 = 1 (top bit masked).
- All-0xFF blocks for 3 blocks, then zero blocks: no coef_valid during the first 3 blocks; 4 blocks are requested before coef 0 appears.
- Backpressure, coef_ready toggled 1-in-3 pseudo-randomly, zero data:
  - coef_data and coef_idx never change while valid && !ready.
  - No index skipped or repeated.
  - Total is exactly 256.
- Handshake ordering:
  - Hold blk_rts=1 for 10 cycles after the latch: no new blk_req until blk_rts=0.
  - Change blk_data after the latch: output unaffected.
- Reset: assert reset=0 mid-SAMPLE at cnt=100 -> all outputs 0 immediately; after release and a new rtr, coef_idx restarts at 0.
